// File: rtl/mutex_req_ctrl.sv
// Per-input-port request controller feeding the router mutex: buffers flits,
// holds a 4-phase req/grant handshake for the duration of each packet.
module mutex_req_ctrl #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_head,
    input  logic              in_tail,
    output logic              req,
    input  logic              grant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_tail,
    output logic              drop_err,
    output logic              proto_err
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned EW = DATA_W + 2;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        REL  = 2'd3
    } state_t;

    state_t state, next_state;

    logic [EW-1:0]          mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [AW:0]            count;
    logic                   full, empty;
    logic                   push, pop;
    logic                   accept_en;
    logic [EW-1:0]          head_entry;
    logic                   head_bit, tail_bit;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   grant_s;
    logic                   fwd_pop, drop, set_proto, req_d;

    // ---------------- input buffer ----------------
    assign full       = (count == DEPTH_C);
    assign empty      = (count == '0);
    // accept_en keeps in_ready low while reset is held and until the first edge after release
    assign in_ready   = accept_en & ~full;
    assign push       = in_valid & in_ready;
    assign pop        = fwd_pop | drop;
    assign head_entry = mem[rd_ptr];
    assign head_bit   = head_entry[EW-1];
    assign tail_bit   = head_entry[EW-2];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_head, in_tail, in_data};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ---------------- grant synchronizer ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], grant};
    end
    assign grant_s = sync_q[SYNC_STAGES-1];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            req       <= 1'b0;
            drop_err  <= 1'b0;
            proto_err <= 1'b0;
            accept_en <= 1'b0;
        end else begin
            state     <= next_state;
            req       <= req_d;
            drop_err  <= drop;
            accept_en <= 1'b1;
            if (set_proto) proto_err <= 1'b1;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (!empty && head_bit)  next_state = REQ;
            REQ:  if (grant_s)             next_state = XFER;
            XFER: if (fwd_pop && tail_bit) next_state = REL;
            REL:  if (!grant_s)            next_state = IDLE;
            default:                       next_state = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        out_valid = (state == XFER) && !empty;
        fwd_pop   = out_valid && out_ready;
        drop      = (state == IDLE) && !empty && !head_bit;
        set_proto = (state == XFER) && !grant_s;
        // req is registered from the next state so it only rises out of IDLE and falls on the tail pop
        req_d     = (next_state == REQ) || (next_state == XFER);
        out_data  = out_valid ? head_entry[DATA_W-1:0] : '0;
        out_tail  = out_valid ? tail_bit : 1'b0;
    end

endmodule

// File: tb/tb_mutex_req_ctrl.sv
// Scoreboard bench for mutex_req_ctrl; mutex grant is modelled as grant=req unless overridden.
module tb_mutex_req_ctrl;

    localparam int unsigned DATA_W      = 16;
    localparam int unsigned FIFO_DEPTH  = 4;
    localparam int unsigned SYNC_STAGES = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid, in_ready, in_head, in_tail;
    logic [DATA_W-1:0] in_data;
    logic              req, grant;
    logic              out_valid, out_ready, out_tail;
    logic [DATA_W-1:0] out_data;
    logic              drop_err, proto_err;
    logic              force_en, force_val;

    typedef struct packed {
        logic              tail;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;
    logic pending_tail = 1'b0;

    always #5 clk = ~clk;
    always_comb grant = force_en ? force_val : req;

    mutex_req_ctrl #(
        .DATA_W      (DATA_W),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_head   (in_head),
        .in_tail   (in_tail),
        .req       (req),
        .grant     (grant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tail  (out_tail),
        .drop_err  (drop_err),
        .proto_err (proto_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Output monitor: a transfer seen at the negedge happens at the following posedge.
    always @(negedge clk) begin
        if (reset) begin
            if (pending_tail) begin
                check("req_fall_after_tail", 32'(req), 32'd0);
                pending_tail = 1'b0;
            end
            if (out_valid && out_ready) begin
                check("req_held_during_xfer", 32'(req), 32'd1);
                if (sbq.size() == 0) begin
                    check("unexpected_flit", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("out_data", 32'(out_data), 32'(e.data));
                    check("out_tail", 32'(out_tail), 32'(e.tail));
                    if (e.tail) pending_tail = 1'b1;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic h, input logic t, input logic [DATA_W-1:0] d, input logic deliver);
        bit done = 0;
        in_valid = 1'b1;
        in_head  = h;
        in_tail  = t;
        in_data  = d;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        in_valid = 1'b0;
        if (!done) check("send_timeout", 32'd0, 32'd1);
        else if (deliver) sbq.push_back('{tail: t, data: d});
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sbq.size() != 0; i++) cyc(1);
        check("drain_empty", 32'(sbq.size()), 32'd0);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && 32'(dut.state) != 32'd0; i++) cyc(1);
        check("back_to_idle", 32'(dut.state), 32'd0);
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_head   = 1'b0;
        in_tail   = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        force_en  = 1'b0;
        force_val = 1'b0;

        // reset state
        cyc(3);
        check("rst_req", 32'(req), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_errs", {30'd0, drop_err, proto_err}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        cyc(1);
        check("in_ready_after_release", 32'(in_ready), 32'd1);

        // single-flit packet with latency checks
        send(1'b1, 1'b1, 16'hA5A5, 1'b1);
        check("req_low_at_push", 32'(req), 32'd0);
        cyc(1);
        check("req_rise", 32'(req), 32'd1);
        cyc(SYNC_STAGES);
        check("out_valid_early", 32'(out_valid), 32'd0);
        cyc(1);
        check("out_valid_latency", 32'(out_valid), 32'd1);
        check("single_data", 32'(out_data), 32'h0000_A5A5);
        cyc(1);
        check("req_fall_single", 32'(req), 32'd0);
        cyc(SYNC_STAGES);
        check("still_rel", 32'(dut.state), 32'd3);
        cyc(1);
        check("idle_after_rel", 32'(dut.state), 32'd0);

        // 4-flit packet, out_ready toggling
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++)
            send(i == 1, i == 4, 16'(i), 1'b1);
        for (int i = 0; i < 40 && sbq.size() != 0; i++) begin
            out_ready = (i % 2 == 0);
            cyc(1);
        end
        out_ready = 1'b1;
        check("four_flit_drained", 32'(sbq.size()), 32'd0);
        wait_idle(20);

        // orphan body flit in IDLE
        send(1'b0, 1'b0, 16'h0007, 1'b0);
        check("orphan_drop_pre", 32'(drop_err), 32'd0);
        cyc(1);
        check("orphan_drop_pulse", 32'(drop_err), 32'd1);
        check("orphan_fifo_empty", 32'(dut.count), 32'd0);
        cyc(1);
        check("orphan_drop_once", 32'(drop_err), 32'd0);
        check("orphan_no_req", 32'(req), 32'd0);

        // FIFO full with grant held low, then drain across pointer wrap
        force_en  = 1'b1;
        force_val = 1'b0;
        for (int i = 0; i < 4; i++)
            send(i == 0, 1'b0, 16'h0100 + 16'(i), 1'b1);
        check("full_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_head  = 1'b0;
        in_tail  = 1'b0;
        in_data  = 16'h0104;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_stall", {31'd0, in_ready}, 32'd0);
            check("full_count", 32'(dut.count), 32'd4);
        end
        force_en = 1'b0;
        send(1'b0, 1'b0, 16'h0104, 1'b1);
        send(1'b0, 1'b1, 16'h0105, 1'b1);
        wait_drain(60);
        wait_idle(20);

        // grant withdrawn mid-packet; mid-packet head forwarded as payload
        out_ready = 1'b0;
        send(1'b1, 1'b0, 16'h0010, 1'b1);
        send(1'b1, 1'b0, 16'h0011, 1'b1);
        send(1'b0, 1'b1, 16'h0012, 1'b1);
        for (int i = 0; i < 20 && !out_valid; i++) cyc(1);
        check("xfer_reached", 32'(out_valid), 32'd1);
        check("proto_clear", 32'(proto_err), 32'd0);
        force_en  = 1'b1;
        force_val = 1'b0;
        cyc(SYNC_STAGES + 1);
        check("proto_set", 32'(proto_err), 32'd1);
        out_ready = 1'b1;
        wait_drain(40);
        wait_idle(20);
        force_en = 1'b0;
        cyc(3);
        check("proto_sticky", 32'(proto_err), 32'd1);

        // reset while in REQ with two flits buffered
        force_en  = 1'b1;
        force_val = 1'b0;
        send(1'b1, 1'b0, 16'h0020, 1'b0);
        send(1'b0, 1'b0, 16'h0021, 1'b0);
        #2;
        check("req_before_reset", 32'(req), 32'd1);
        reset = 1'b0;
        #1;
        check("async_req_drop", 32'(req), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_fifo_empty", 32'(dut.count), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_proto_clr", 32'(proto_err), 32'd0);
        repeat (2) @(negedge clk);
        reset    = 1'b1;
        force_en = 1'b0;
        cyc(1);
        check("in_ready_after_rerelease", 32'(in_ready), 32'd1);
        send(1'b1, 1'b1, 16'hBEEF, 1'b1);
        wait_drain(40);
        wait_idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
